// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path:
//   - tx_state_t      : transmit FSM state encoding
//   - PAR_EVEN/PAR_ODD: values of the par_typ input
//   - DEFAULT_PRESCALE: bit period used when the prescale input is 0 or 1
//   - effective_prescale(): maps a raw prescale input to the bit period used
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_WIDTH = 5;
    localparam logic [PRESCALE_WIDTH-1:0] DEFAULT_PRESCALE = 5'd16;

    // A bit period shorter than two cycles is meaningless for the
    // oversampling receiver, so 0 and 1 fall back to the default rate.
    function automatic logic [PRESCALE_WIDTH-1:0] effective_prescale(
        input logic [PRESCALE_WIDTH-1:0] raw
    );
        logic [PRESCALE_WIDTH-1:0] eff;
        if (raw < 5'd2) begin
            eff = DEFAULT_PRESCALE;
        end else begin
            eff = raw;
        end
        return eff;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_timer
// Edge (per-bit cycle) counter and data-bit index counter for the UART
// transmitter, structured like the receive-side edge/bit counter.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : FSM is in a non-idle state; counters run
//   data_phase    : FSM is in the DATA state; bit index advances
//   prescale_eff  : latched bit period in clock cycles (2..31)
//   bit_tick      : terminal edge count, the current bit ends at this edge
//   last_bit      : bit index points at the final data bit
// -----------------------------------------------------------------------------
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int BIT_COUNTER_WIDTH  = 4,
    parameter int EDGE_COUNTER_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      data_phase,
    input  logic [PRESCALE_WIDTH-1:0] prescale_eff,
    output logic                      bit_tick,
    output logic                      last_bit
);

    logic [EDGE_COUNTER_WIDTH-1:0] edge_cnt_r;
    logic [BIT_COUNTER_WIDTH-1:0]  bit_idx_r;
    logic                          terminal_s;

    assign terminal_s = (edge_cnt_r == EDGE_COUNTER_WIDTH'(prescale_eff - 5'd1));
    assign bit_tick   = enable && terminal_s;
    assign last_bit   = (bit_idx_r == BIT_COUNTER_WIDTH'(DATA_WIDTH - 1));

    // Per-bit cycle counter: held at zero while idle so every frame starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_r <= '0;
        end else if (!enable) begin
            edge_cnt_r <= '0;
        end else if (terminal_s) begin
            edge_cnt_r <= '0;
        end else begin
            edge_cnt_r <= edge_cnt_r + 1'b1;
        end
    end

    // Data-bit index: only moves during DATA, otherwise parked at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_r <= '0;
        end else if (enable && data_phase) begin
            if (bit_tick) begin
                if (last_bit) begin
                    bit_idx_r <= '0;
                end else begin
                    bit_idx_r <= bit_idx_r + 1'b1;
                end
            end else begin
                bit_idx_r <= bit_idx_r;
            end
        end else begin
            bit_idx_r <= '0;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter: serialises one word as start / data (LSB first) /
// optional parity / stop, one bit every effective-prescale clock cycles.
// Ports:
//   clk, rst   : oversampling clock, synchronous active-high reset
//   p_data     : word to transmit, latched when a frame is accepted
//   data_valid : request to send p_data (ignored while a frame is busy)
//   par_en     : append a parity bit
//   par_typ    : 0 = even parity, 1 = odd parity
//   prescale   : clock cycles per bit (0/1 mean 16), latched per frame
//   tx_out     : registered serial line, idle high
//   busy       : registered, high for the duration of the frame on tx_out
//   tx_done    : registered one-cycle pulse as busy falls
// All outputs are registered from the current state, so the line follows the
// FSM by one cycle; busy and tx_done are aligned with the line, not the FSM.
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int BIT_COUNTER_WIDTH  = 4,
    parameter int EDGE_COUNTER_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [4:0]            prescale,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    // Parity over the data word; odd parity is the inverse of the XOR.
    function automatic logic frame_parity(
        input logic [DATA_WIDTH-1:0] word,
        input logic                  typ
    );
        logic p;
        p = ^word;
        if (typ == PAR_ODD) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

    tx_state_t                 state_r;
    tx_state_t                 state_next_s;
    logic [DATA_WIDTH-1:0]     shift_r;
    logic                      par_en_r;
    logic                      par_bit_r;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic                      tx_out_r;
    logic                      busy_r;
    logic                      tx_done_r;
    logic                      line_s;
    logic                      busy_s;
    logic                      done_s;
    logic                      start_s;
    logic                      timer_en_s;
    logic                      data_phase_s;
    logic                      bit_tick_s;
    logic                      last_bit_s;

    // busy_r is still high in the first IDLE cycle (the last stop-bit cycle on
    // the line), so a request there is dropped; this guarantees one idle-high
    // cycle after the tx_done cycle before the next start bit.
    assign start_s      = (state_r == IDLE) && data_valid && !busy_r;
    assign timer_en_s   = (state_r != IDLE);
    assign data_phase_s = (state_r == DATA);

    uart_tx_bit_timer #(
        .DATA_WIDTH         (DATA_WIDTH),
        .BIT_COUNTER_WIDTH  (BIT_COUNTER_WIDTH),
        .EDGE_COUNTER_WIDTH (EDGE_COUNTER_WIDTH)
    ) u_bit_timer (
        .clk          (clk),
        .rst          (rst),
        .enable       (timer_en_s),
        .data_phase   (data_phase_s),
        .prescale_eff (prescale_r),
        .bit_tick     (bit_tick_s),
        .last_bit     (last_bit_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: every non-idle state lasts one bit period.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_tick_s && last_bit_s) begin
                    if (par_en_r) begin
                        state_next_s = PARITY;
                    end else begin
                        state_next_s = STOP;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (bit_tick_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                if (bit_tick_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Frame datapath: latch the request at acceptance, shift data out LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= '0;
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            prescale_r <= DEFAULT_PRESCALE;
        end else if (start_s) begin
            shift_r    <= p_data;
            par_en_r   <= par_en;
            par_bit_r  <= frame_parity(p_data, par_typ);
            prescale_r <= effective_prescale(prescale);
        end else if (data_phase_s && bit_tick_s) begin
            shift_r    <= {1'b0, shift_r[DATA_WIDTH-1:1]};
            par_en_r   <= par_en_r;
            par_bit_r  <= par_bit_r;
            prescale_r <= prescale_r;
        end else begin
            shift_r    <= shift_r;
            par_en_r   <= par_en_r;
            par_bit_r  <= par_bit_r;
            prescale_r <= prescale_r;
        end
    end

    // FSM output logic: line level, busy and completion for the next cycle.
    always_comb begin
        line_s = 1'b1;
        busy_s = (state_r != IDLE);
        done_s = busy_r && (state_r == IDLE);
        case (state_r)
            IDLE:    line_s = 1'b1;
            START:   line_s = 1'b0;
            DATA:    line_s = shift_r[0];
            PARITY:  line_s = par_bit_r;
            STOP:    line_s = 1'b1;
            default: line_s = 1'b1;
        endcase
    end

    // Output registers: no combinational path from inputs to the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_out_r  <= 1'b1;
            busy_r    <= 1'b0;
            tx_done_r <= 1'b0;
        end else begin
            tx_out_r  <= line_s;
            busy_r    <= busy_s;
            tx_done_r <= done_s;
        end
    end

    assign tx_out  = tx_out_r;
    assign busy    = busy_r;
    assign tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Scoreboard bench: each scenario pushes the expected per-cycle
// {tx_out, busy, tx_done} triple into exp_q while driving stimulus, then pops
// and compares one entry per clock, sampling on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [4:0] prescale;
    logic       tx_out;
    logic       busy;
    logic       tx_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_frame #(
        .DATA_WIDTH         (8),
        .BIT_COUNTER_WIDTH  (4),
        .EDGE_COUNTER_WIDTH (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // Reference model: line bits for one frame, then the tx_done cycle.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input int eff);
        logic b;
        repeat (eff) exp_q.push_back({1'b0, 1'b1, 1'b0});
        for (int i = 0; i < 8; i++) begin
            b = d[i];
            repeat (eff) exp_q.push_back({b, 1'b1, 1'b0});
        end
        if (pe) begin
            b = (^d) ^ pt;
            repeat (eff) exp_q.push_back({b, 1'b1, 1'b0});
        end
        repeat (eff) exp_q.push_back({1'b1, 1'b1, 1'b0});
        exp_q.push_back({1'b1, 1'b0, 1'b1});
    endtask

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back({1'b1, 1'b0, 1'b0});
    endtask

    // Present a request for exactly one rising edge.
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [4:0] ps);
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; prescale = ps; data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] e;
        rst = 1'b1; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; prescale = 5'd8;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({tx_out, busy, tx_done} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_values: got %b required 100", {tx_out, busy, tx_done});
        end
        // Reset and valid together: reset wins, nothing is latched.
        p_data = 8'h81; data_valid = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({tx_out, busy, tx_done} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_beats_valid: got %b required 100", {tx_out, busy, tx_done});
        end
        rst = 1'b0; data_valid = 1'b0;
        push_idle(6);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({tx_out, busy, tx_done} !== e) begin
                tests_failed++;
                $display("FAIL reset_idle: got %b required %b", {tx_out, busy, tx_done}, e);
            end
        end
    endtask

    task automatic test_parity_even_a5();
        logic [2:0] e;
        int idx = 0;
        int busy_cnt = 0;
        logic [10:0] line_seen = '0;
        push_idle(1);
        push_frame(8'hA5, 1'b1, 1'b0, 8);
        start_frame(8'hA5, 1'b1, 1'b0, 5'd8);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({tx_out, busy, tx_done} !== e) begin
                tests_failed++;
                $display("FAIL a5_even cycle %0d: got %b required %b", idx, {tx_out, busy, tx_done}, e);
            end
            if (busy === 1'b1) busy_cnt++;
            // Mid-bit sample of each of the 11 bit slots.
            if (idx >= 1 && idx <= 88 && ((idx - 1) % 8) == 4) line_seen[(idx - 1) / 8] = tx_out;
            idx++;
        end
        tests_run++;
        if (line_seen !== 11'b10101001010) begin
            tests_failed++;
            $display("FAIL a5_even_line: got %b required 10101001010 (slot0 at right)", line_seen);
        end
        tests_run++;
        if (busy_cnt !== 88) begin
            tests_failed++;
            $display("FAIL a5_even_busy_len: got %0d required 88", busy_cnt);
        end
    endtask

    task automatic test_no_parity_ff();
        logic [2:0] e;
        int idx = 0;
        int busy_cnt = 0;
        push_idle(1);
        push_frame(8'hFF, 1'b0, 1'b0, 16);
        start_frame(8'hFF, 1'b0, 1'b0, 5'd16);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({tx_out, busy, tx_done} !== e) begin
                tests_failed++;
                $display("FAIL ff_nopar cycle %0d: got %b required %b", idx, {tx_out, busy, tx_done}, e);
            end
            if (busy === 1'b1) busy_cnt++;
            idx++;
        end
        tests_run++;
        if (busy_cnt !== 160) begin
            tests_failed++;
            $display("FAIL ff_nopar_busy_len: got %0d required 160", busy_cnt);
        end
    endtask

    task automatic test_odd_parity();
        logic [2:0] e;
        logic [7:0] words [2];
        logic       par_req [2];
        int         idx;
        logic       par_seen;
        words[0] = 8'h00; par_req[0] = 1'b1;
        words[1] = 8'h01; par_req[1] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            idx = 0;
            par_seen = 1'bx;
            push_idle(1);
            push_frame(words[w], 1'b1, 1'b1, 8);
            start_frame(words[w], 1'b1, 1'b1, 5'd8);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                tests_run++;
                if ({tx_out, busy, tx_done} !== e) begin
                    tests_failed++;
                    $display("FAIL odd_par word %h cycle %0d: got %b required %b", words[w], idx, {tx_out, busy, tx_done}, e);
                end
                if (idx == 1 + 8 * 9 + 4) par_seen = tx_out;
                idx++;
            end
            tests_run++;
            if (par_seen !== par_req[w]) begin
                tests_failed++;
                $display("FAIL odd_par_bit word %h: got %b required %b", words[w], par_seen, par_req[w]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        int idx = 0;
        push_idle(1);
        push_frame(8'hC3, 1'b1, 1'b0, 8);
        push_idle(1);
        push_frame(8'h5A, 1'b0, 1'b0, 8);
        start_frame(8'hC3, 1'b1, 1'b0, 5'd8);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({tx_out, busy, tx_done} !== e) begin
                tests_failed++;
                $display("FAIL back_to_back cycle %0d: got %b required %b", idx, {tx_out, busy, tx_done}, e);
            end
            // Entries 1..88 busy, 89 tx_done, 90 idle, 91 next start bit.
            if (idx == 20) begin p_data = 8'h3C; data_valid = 1'b1; end
            if (idx == 21) begin data_valid = 1'b0; end
            if (idx == 87) begin p_data = 8'h5A; par_en = 1'b0; data_valid = 1'b1; end
            if (idx == 90) begin data_valid = 1'b0; end
            idx++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] e;
        int idx = 0;
        push_idle(1);
        push_frame(8'h6E, 1'b1, 1'b1, 8);
        start_frame(8'h6E, 1'b1, 1'b1, 5'd8);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({tx_out, busy, tx_done} !== e) begin
                tests_failed++;
                $display("FAIL rst_mid cycle %0d: got %b required %b", idx, {tx_out, busy, tx_done}, e);
            end
            if (idx == 20) begin
                rst = 1'b1;
                break;
            end
            idx++;
        end
        exp_q.delete();
        @(negedge clk);
        tests_run++;
        if ({tx_out, busy, tx_done} !== 3'b100) begin
            tests_failed++;
            $display("FAIL rst_mid_next_edge: got %b required 100", {tx_out, busy, tx_done});
        end
        rst = 1'b0;
        push_idle(12);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({tx_out, busy, tx_done} !== e) begin
                tests_failed++;
                $display("FAIL rst_mid_no_resume: got %b required %b", {tx_out, busy, tx_done}, e);
            end
        end
        idx = 0;
        push_idle(1);
        push_frame(8'h93, 1'b1, 1'b0, 8);
        start_frame(8'h93, 1'b1, 1'b0, 5'd8);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({tx_out, busy, tx_done} !== e) begin
                tests_failed++;
                $display("FAIL rst_mid_clean_frame cycle %0d: got %b required %b", idx, {tx_out, busy, tx_done}, e);
            end
            idx++;
        end
    endtask

    task automatic test_default_prescale();
        logic [2:0] e;
        int idx = 0;
        int busy_cnt = 0;
        push_idle(1);
        push_frame(8'h55, 1'b0, 1'b0, 16);
        start_frame(8'h55, 1'b0, 1'b0, 5'd0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            tests_run++;
            if ({tx_out, busy, tx_done} !== e) begin
                tests_failed++;
                $display("FAIL prescale0 cycle %0d: got %b required %b", idx, {tx_out, busy, tx_done}, e);
            end
            if (busy === 1'b1) busy_cnt++;
            if (idx == 30) prescale = 5'd8;
            idx++;
        end
        tests_run++;
        if (busy_cnt !== 160) begin
            tests_failed++;
            $display("FAIL prescale0_busy_len: got %0d required 160", busy_cnt);
        end
    endtask

    // Bound on total run time in case the stimulus sequencing ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_parity_even_a5();
        test_no_parity_ff();
        test_odd_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_default_prescale();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
